// File: rtl/lcd_pkg.sv
// Shared encodings and constants for the 1602 frame scheduler.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_ACK,
      S_BUSY,
      S_SETTLE
   } state_e;

   localparam logic [7:0] I_SET_DDRAM_L0 = 8'h80;
   localparam logic [7:0] I_SET_DDRAM_L1 = 8'hC0;
   localparam logic [7:0] C_BLANK        = 8'h20;
   localparam int         C_LINE_LEN     = 16;

   function automatic logic [7:0] ddram_cmd(input logic line);
      return line ? I_SET_DDRAM_L1 : I_SET_DDRAM_L0;
   endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// 32x8 character store: synchronous write, asynchronous read, resets to blanks.
module lcd_frame_ram
   import lcd_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_wr_en,
   input  logic [4:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   input  logic [4:0] i_rd_addr,
   output logic [7:0] o_rd_data
);

   logic [7:0] mem_q [32];
   logic [7:0] mem_d [32];

   always_comb begin
      mem_d = mem_q;
      if (i_wr_en) mem_d[i_wr_addr] = i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < 32; i++) mem_q[i] <= C_BLANK;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Dirty-line redraw scheduler for a 2x16 character panel; one set-address plus
// 16 data bytes per dirty line, paced by the transmitter busy handshake.
//
// state    | meaning
// S_IDLE   | waiting for i_ready and a dirty line
// S_ISSUE  | waiting for i_busy low, then strobing the current step
// S_ACK    | waiting for i_busy to rise; timeout re-issues the same step
// S_BUSY   | transmitter working; waiting for i_busy low
// S_SETTLE | post-byte settle delay before the next step or line end
module lcd_frame_scheduler
   import lcd_pkg::*;
#(
   parameter int P_SETTLE = 5000,
   parameter int P_ACK_TO = 8,
   parameter int P_CNT_W  = 16
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_ready,
   input  logic       i_wr_en,
   input  logic [4:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   input  logic       i_refresh,
   input  logic       i_busy,
   output logic       o_cs,
   output logic       o_rs,
   output logic [7:0] o_data,
   output logic       o_active,
   output logic       o_done
);

   localparam logic [P_CNT_W-1:0] SETTLE_LAST = P_CNT_W'(P_SETTLE - 1);
   localparam logic [P_CNT_W-1:0] ACK_LAST    = P_CNT_W'(P_ACK_TO - 1);
   localparam logic [4:0]         LAST_STEP   = 5'(C_LINE_LEN);

   state_e              state_q, state_d;
   logic [4:0]          step_q, step_d;
   logic                line_q, line_d;
   logic [P_CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]          dirty_q, dirty_d;
   logic                cs_q, cs_d;
   logic                rs_q, rs_d;
   logic [7:0]          data_q, data_d;
   logic                done_q, done_d;

   logic [7:0]          wr_data_m;
   logic [3:0]          pos;
   logic [4:0]          rd_addr;
   logic [7:0]          rd_data;

   // NUL is stored as a blank so the panel never shows a CGRAM glyph by accident.
   assign wr_data_m = (i_wr_data == 8'h00) ? C_BLANK : i_wr_data;
   assign pos       = step_q[3:0] - 4'd1;
   assign rd_addr   = {line_q, pos};

   lcd_frame_ram u_ram (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (wr_data_m),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      line_d  = line_q;
      cnt_d   = cnt_q;
      dirty_d = dirty_q;
      cs_d    = 1'b0;
      rs_d    = rs_q;
      data_d  = data_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_ready && (dirty_q != 2'b00)) begin
               line_d          = ~dirty_q[0];
               dirty_d[line_d] = 1'b0;
               step_d          = 5'd0;
               state_d         = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!i_busy) begin
               cs_d = 1'b1;
               if (step_q == 5'd0) begin
                  rs_d   = 1'b0;
                  data_d = ddram_cmd(line_q);
               end else begin
                  rs_d   = 1'b1;
                  data_d = rd_data;
               end
               cnt_d   = '0;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (i_busy) begin
               state_d = S_BUSY;
            end else if (cnt_q == ACK_LAST) begin
               state_d = S_ISSUE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BUSY: begin
            if (!i_busy) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               if (step_q == LAST_STEP) begin
                  state_d = S_IDLE;
               end else begin
                  step_d  = step_q + 5'd1;
                  state_d = S_ISSUE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Host activity is applied last so it overrides the launch-time clear.
      if (i_wr_en)   dirty_d[i_wr_addr[4]] = 1'b1;
      if (i_refresh) dirty_d = 2'b11;

      if ((state_q == S_SETTLE) && (state_d == S_IDLE) && (dirty_d == 2'b00))
         done_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         step_q  <= 5'd0;
         line_q  <= 1'b0;
         cnt_q   <= '0;
         dirty_q <= 2'b11;
         cs_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         line_q  <= line_d;
         cnt_q   <= cnt_d;
         dirty_q <= dirty_d;
         cs_q    <= cs_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign o_cs     = cs_q;
   assign o_rs     = rs_q;
   assign o_data   = data_q;
   assign o_done   = done_q;
   assign o_active = (state_q != S_IDLE);

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Holds a 2x16 character frame buffer for the 1602 panel and redraws only the lines that changed.
- Sits between host logic (counters, UART, key scanner) and the LCD byte transmitter, which owns the E strobe and drives i_busy.
- Runs after panel initialisation has completed (i_ready high).
- For each dirty line, issues one DDRAM set-address command followed by 16 data bytes, each gated by the transmitter busy handshake plus a settle delay.

Parameters:
- P_SETTLE, 5000, clock cycles to wait after i_busy falls before the next issue (40 us at 125 MHz).
- P_ACK_TO, 8, cycles to wait for i_busy to rise after o_cs before the same byte is re-issued.
- P_CNT_W, 16, width of the settle/timeout counter; must satisfy 2^P_CNT_W > P_SETTLE.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous reset, active-low
- i_ready  in  1  panel initialisation complete; sampled only in S_IDLE
- i_wr_en  in  1  host frame-buffer write strobe
- i_wr_addr  in  5  host write address: 0-15 = line 0, 16-31 = line 1
- i_wr_data  in  8  character code
- i_refresh  in  1  one-cycle pulse; marks both lines dirty
- i_busy  in  1  transmitter busy
- o_cs  out  1  one-cycle issue strobe to the transmitter
- o_rs  out  1  0 = command, 1 = data
- o_data  out  8  byte to the transmitter
- o_active  out  1  a line redraw is in progress
- o_done  out  1  one-cycle pulse when S_IDLE is re-entered with no lines dirty

Behaviour:
- Reset (asynchronous, i_reset_n low):
  - o_cs, o_rs and o_data are 0; o_active and o_done are 0.
  - State = S_IDLE.
  - All 32 buffer bytes = 0x20.
  - dirty = 2'b11, so a blank screen is drawn once i_ready rises.
- Reset mid-transfer: abandons the transfer immediately with no completion; both lines redraw afterwards.
- Buffer writes:
  - Accepted on every cycle regardless of state.
  - Set dirty[i_wr_addr[4]].
  - A write with data 0x00 stores 0x20.
- i_refresh sets both dirty bits.
- States:
  - S_IDLE:
    - Leave only if i_ready is high and dirty is nonzero.
    - Select the line: line 0 if dirty[0], else line 1.
    - Clear that line's dirty bit; a same-cycle write or refresh to that line wins, leaving it set.
    - Set step = 0 and go to S_ISSUE.
  - S_ISSUE:
    - Wait for i_busy low.
    - Then pulse o_cs for exactly 1 cycle, with o_rs and o_data registered on the same edge.
    - Step 0: rs = 0, data = 0x80 (line 0) or 0xC0 (line 1).
    - Steps 1-16: rs = 1, data = buffer[line*16 + step - 1], read at issue time.
    - Clear the counter and go to S_ACK.
  - S_ACK:
    - If i_busy goes high, go to S_BUSY.
    - If the counter reaches P_ACK_TO first, return to S_ISSUE with the same step (re-issue).
  - S_BUSY: on i_busy low, clear the counter and go to S_SETTLE.
  - S_SETTLE:
    - At counter == P_SETTLE-1: if step == 16, go to S_IDLE; else step+1 and go to S_ISSUE.
- Between strobes:
  - o_rs and o_data hold their last issued value; o_cs stays 0.
  - Minimum spacing between two o_cs pulses is 1 + 1 + busy length + P_SETTLE cycles.
- Timing:
  - o_cs rises 1 cycle after the S_IDLE exit decision.
  - A full line = 17 transactions.
- o_active is high in every state except S_IDLE.
- o_done fires on the transition from S_SETTLE to S_IDLE when dirty == 0 on that cycle.
- Mid-redraw writes:
  - Bytes already issued are stale; the line's dirty bit is set again, so the line is redrawn later.
  - Bytes not yet issued are picked up directly.
- i_ready falling mid-line is ignored; the line completes.
- Step counter: 5 bits, never exceeds 16. Line index: 1 bit.

Decomposition:
- Package lcd_pkg holds:
  - state encodings;
  - constants I_SET_DDRAM_L0 = 8'h80 and I_SET_DDRAM_L1 = 8'hC0;
  - C_BLANK = 8'h20;
  - C_LINE_LEN = 16.
- One sub-module, lcd_frame_ram: 32x8 register array with a synchronous write port, an asynchronous read port and reset-to-0x20.
- The FSM, counter and dirty logic stay in the top module.

Test Plan:
- Reset, hold i_ready = 0 for 100 cycles -> no o_cs. Raise i_ready, with the transmitter model asserting busy for 10 cycles per byte -> 0x80 (rs=0), then 16×0x20 (rs=1), then 0xC0, then 16×0x20; exactly one o_done pulse; each gap = P_SETTLE after busy falls.
- Write 'A' (0x41) at addr 17 while idle with dirty = 0 -> only line 1 redrawn: 0xC0, then 0x20, 0x41, then 14×0x20; line 0 untouched.
- While line 0 is at step 10, write addr 3 = 0x42 -> line 0 finishes with the stale byte at position 3, then line 0 is redrawn with 0x42 at position 3; o_done only after the second pass.
- Transmitter model ignores the first o_cs (no busy for P_ACK_TO cycles) -> same byte is re-issued, identical rs/data; the sequence then proceeds normally.
- Write 0x00 at addr 0 -> redraw sends 0x20 at position 0.
- Assert i_reset_n low mid-line -> outputs 0 immediately. After release with i_ready high, a full two-line blank redraw.
